threshold_crossing_detector: RTL and testbench

Streaming threshold monitor built on unsigned magnitude comparison with hysteresis and debounce. It consumes a stream of WIDTH-bit samples, compares each one against a high threshold and a low threshold, and tracks a debounced HIGH/LOW state. It emits single-cycle rise/fall pulses and a saturating count of rising crossings. It sits in the datapath directly downstream of the parameterized comparator stage and turns raw lt/eq/gt decisions into qualified events.

---
 rtl/threshold_crossing_detector.sv | 162 ++++++++++++++++
 tb/tb_threshold_crossing_detector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_crossing_detector.sv
`default_nettype none
// ============================================================================
// Module   : threshold_crossing_detector
// Brief    : Debounced hysteresis monitor on an unsigned sample stream with
//            rise/fall pulses and a saturating rise counter.
//            Optional sticky overflow flag: THRESHOLD_CROSSING_DETECTOR_OVF_EN
// Revision : 1.0 - initial release
// ============================================================================
module threshold_crossing_detector #(
    parameter int WIDTH     = 16,
    parameter int DEBOUNCE  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [WIDTH-1:0]     s_data,
    input  logic [WIDTH-1:0]     thr_hi,
    input  logic [WIDTH-1:0]     thr_lo,
    input  logic                 clear,
    output logic                 state_hi,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] event_cnt,
    output logic                 cfg_err
`ifdef THRESHOLD_CROSSING_DETECTOR_OVF_EN
    ,
    output logic                 cnt_ovf
`endif
);

    localparam int                   c_RUN_W    = $clog2(DEBOUNCE + 1);
    localparam logic [c_RUN_W-1:0]   c_DEBOUNCE = c_RUN_W'(DEBOUNCE);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;

    localparam logic [1:0] c_ST_LOW     = 2'd0;
    localparam logic [1:0] c_ST_PEND_HI = 2'd1;
    localparam logic [1:0] c_ST_HIGH    = 2'd2;
    localparam logic [1:0] c_ST_PEND_LO = 2'd3;

    logic [1:0]           r_state;
    logic [c_RUN_W-1:0]   r_run;
    logic                 r_state_hi;
    logic                 r_rise;
    logic                 r_fall;
    logic [CNT_WIDTH-1:0] r_event_cnt;
    logic                 r_cfg_err;

    logic                 w_cfg_bad;
    logic                 w_above;
    logic                 w_below;
    logic [c_RUN_W-1:0]   w_run_inc;
    logic [1:0]           w_nxt_state;
    logic [c_RUN_W-1:0]   w_nxt_run;
    logic                 w_rise_evt;
    logic                 w_fall_evt;

    assign w_cfg_bad = (thr_lo > thr_hi);
    assign w_above   = (s_data > thr_hi);
    assign w_below   = (s_data < thr_lo);
    assign w_run_inc = r_run + 1'b1;

    // LOW shares the PEND_HI path: run is 0 there, so DEBOUNCE=1 crosses at once.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_run   = r_run;
        w_rise_evt  = 1'b0;
        w_fall_evt  = 1'b0;
        if (s_valid && !w_cfg_bad) begin
            case (r_state)
                c_ST_LOW, c_ST_PEND_HI: begin
                    if (w_above) begin
                        if (w_run_inc == c_DEBOUNCE) begin
                            w_nxt_state = c_ST_HIGH;
                            w_nxt_run   = '0;
                            w_rise_evt  = 1'b1;
                        end else begin
                            w_nxt_state = c_ST_PEND_HI;
                            w_nxt_run   = w_run_inc;
                        end
                    end else begin
                        w_nxt_state = c_ST_LOW;
                        w_nxt_run   = '0;
                    end
                end
                default: begin
                    if (w_below) begin
                        if (w_run_inc == c_DEBOUNCE) begin
                            w_nxt_state = c_ST_LOW;
                            w_nxt_run   = '0;
                            w_fall_evt  = 1'b1;
                        end else begin
                            w_nxt_state = c_ST_PEND_LO;
                            w_nxt_run   = w_run_inc;
                        end
                    end else begin
                        w_nxt_state = c_ST_HIGH;
                        w_nxt_run   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_LOW;
            r_run       <= '0;
            r_state_hi  <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_event_cnt <= '0;
            r_cfg_err   <= 1'b0;
        end else if (clear) begin
            r_state     <= c_ST_LOW;
            r_run       <= '0;
            r_state_hi  <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_event_cnt <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_run      <= w_nxt_run;
            r_state_hi <= (w_nxt_state == c_ST_HIGH) || (w_nxt_state == c_ST_PEND_LO);
            r_rise     <= w_rise_evt;
            r_fall     <= w_fall_evt;
            if (s_valid) begin
                r_cfg_err <= w_cfg_bad;
            end
            if (w_rise_evt && (r_event_cnt != c_CNT_MAX)) begin
                r_event_cnt <= r_event_cnt + 1'b1;
            end
        end
    end

`ifdef THRESHOLD_CROSSING_DETECTOR_OVF_EN
    logic r_cnt_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ovf <= 1'b0;
        end else if (clear) begin
            r_cnt_ovf <= 1'b0;
        end else if (w_rise_evt && (r_event_cnt == c_CNT_MAX)) begin
            r_cnt_ovf <= 1'b1;
        end
    end

    assign cnt_ovf = r_cnt_ovf;
`else
    // Saturation is silent in this build.
`endif

    assign state_hi  = r_state_hi;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign event_cnt = r_event_cnt;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_threshold_crossing_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_threshold_crossing_detector
// Brief    : Randomized + directed bench for threshold_crossing_detector with
//            a behavioural model; two instances (CNT_WIDTH 8 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_threshold_crossing_detector;

    localparam int c_W = 16;
    localparam int c_D = 3;

    logic           clk;
    logic           rst_n;
    logic           s_valid;
    logic [c_W-1:0] s_data;
    logic [c_W-1:0] thr_hi;
    logic [c_W-1:0] thr_lo;
    logic           clear;

    logic       st8, rise8, fall8, cerr8;
    logic [7:0] cnt8;
    logic       st2, rise2, fall2, cerr2;
    logic [1:0] cnt2;
`ifdef THRESHOLD_CROSSING_DETECTOR_OVF_EN
    logic       ovf8, ovf2;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_hi, m_rise, m_fall, m_cerr, m_ovf8, m_ovf2;
    int m_run, m_cnt8, m_cnt2;

    threshold_crossing_detector #(.WIDTH(c_W), .DEBOUNCE(c_D), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .state_hi(st8), .rise(rise8), .fall(fall8), .event_cnt(cnt8), .cfg_err(cerr8)
`ifdef THRESHOLD_CROSSING_DETECTOR_OVF_EN
        , .cnt_ovf(ovf8)
`endif
    );

    threshold_crossing_detector #(.WIDTH(c_W), .DEBOUNCE(c_D), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear(clear),
        .state_hi(st2), .rise(rise2), .fall(fall2), .event_cnt(cnt2), .cfg_err(cerr2)
`ifdef THRESHOLD_CROSSING_DETECTOR_OVF_EN
        , .cnt_ovf(ovf2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_hi = 0; m_rise = 0; m_fall = 0; m_cerr = 0; m_ovf8 = 0; m_ovf2 = 0;
        m_run = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    // One clock edge of the specified behaviour, from the current inputs.
    task automatic model_step();
        bit q;
        m_rise = 0;
        m_fall = 0;
        if (clear) begin
            model_reset();
        end else if (s_valid) begin
            if (thr_lo > thr_hi) begin
                m_cerr = 1;
            end else begin
                m_cerr = 0;
                q = m_hi ? (s_data < thr_lo) : (s_data > thr_hi);
                m_run = q ? m_run + 1 : 0;
                if (m_run == c_D) begin
                    m_run = 0;
                    if (!m_hi) begin
                        m_rise = 1;
                        if (m_cnt8 == 255) m_ovf8 = 1; else m_cnt8++;
                        if (m_cnt2 == 3)   m_ovf2 = 1; else m_cnt2++;
                    end else begin
                        m_fall = 1;
                    end
                    m_hi = !m_hi;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("state_hi",  int'(st8),   int'(m_hi));
        chk("rise",      int'(rise8), int'(m_rise));
        chk("fall",      int'(fall8), int'(m_fall));
        chk("event_cnt", int'(cnt8),  m_cnt8);
        chk("cfg_err",   int'(cerr8), int'(m_cerr));
        chk("s.state_hi",  int'(st2),   int'(m_hi));
        chk("s.rise",      int'(rise2), int'(m_rise));
        chk("s.fall",      int'(fall2), int'(m_fall));
        chk("s.event_cnt", int'(cnt2),  m_cnt2);
        chk("s.cfg_err",   int'(cerr2), int'(m_cerr));
        if (rise8 && fall8) chk("rise_and_fall", 1, 0);
`ifdef THRESHOLD_CROSSING_DETECTOR_OVF_EN
        chk("cnt_ovf",   int'(ovf8), int'(m_ovf8));
        chk("s.cnt_ovf", int'(ovf2), int'(m_ovf2));
`endif
    endtask

    task automatic cyc(input bit v, input logic [c_W-1:0] d);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0;
        thr_hi = 16'h0025; thr_lo = 16'h0019;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_cnt", int'(cnt8), 0);
        chk("reset_state", int'(st8), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic rise
        cyc(1, 16'h0030);
        cyc(1, 16'h0030);
        chk("pre_rise", int'(rise8), 0);
        cyc(1, 16'h0030);
        chk("basic_rise", int'(rise8), 1);
        chk("basic_state", int'(st8), 1);
        chk("basic_cnt", int'(cnt8), 1);
        cyc(0, 16'h0000);
        chk("rise_one_cycle", int'(rise8), 0);

        // Hysteresis fall with gaps
        repeat (3) cyc(1, 16'h0019);
        chk("eq_lo_no_fall", int'(st8), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h0018);
            if (i < 2) repeat (2) cyc(0, 16'h0000);
        end
        chk("gap_fall", int'(fall8), 1);
        chk("gap_fall_state", int'(st8), 0);
        cyc(0, 16'h0000);
        chk("fall_one_cycle", int'(fall8), 0);

        // Boundary and glitch
        repeat (5) cyc(1, 16'h0025);
        chk("eq_hi_no_rise", int'(st8), 0);
        cyc(1, 16'h0030); cyc(1, 16'h0030); cyc(1, 16'h0020); cyc(1, 16'h0030);
        chk("glitch_no_rise", int'(st8), 0);
        chk("glitch_cnt", int'(cnt8), 1);
        cyc(1, 16'h0010);

        // Configuration error
        thr_lo = 16'h0030;
        repeat (4) cyc(1, 16'h0040);
        chk("cfg_err_set", int'(cerr8), 1);
        chk("cfg_no_rise", int'(st8), 0);
        chk("cfg_cnt", int'(cnt8), 1);
        thr_lo = 16'h0019;
        cyc(1, 16'h0010);
        chk("cfg_err_clr", int'(cerr8), 0);

        // Clear beats a qualifying sample
        cyc(1, 16'h0030); cyc(1, 16'h0030);
        clear = 1'b1;
        cyc(1, 16'h0030);
        clear = 1'b0;
        chk("clear_cnt", int'(cnt8), 0);
        chk("clear_rise", int'(rise8), 0);
        cyc(1, 16'h0030); cyc(1, 16'h0030);
        chk("post_clear_pend", int'(st8), 0);
        cyc(1, 16'h0030);
        chk("post_clear_rise", int'(rise8), 1);
        chk("post_clear_cnt", int'(cnt8), 1);

        // Async reset while in PEND_HI
        repeat (3) cyc(1, 16'h0010);
        cyc(1, 16'h0030); cyc(1, 16'h0030);
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", int'(cnt8), 0);
        chk("arst_state", int'(st8), 0);
        chk("arst_cerr", int'(cerr8), 0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation on the CNT_WIDTH=2 instance
        for (int k = 0; k < 4; k++) begin
            repeat (3) cyc(1, 16'h0030);
            chk("sat_rise", int'(rise2), 1);
            repeat (3) cyc(1, 16'h0010);
        end
        chk("sat_cnt2", int'(cnt2), 3);
        chk("sat_cnt8", int'(cnt8), 4);
`ifdef THRESHOLD_CROSSING_DETECTOR_OVF_EN
        chk("sat_ovf", int'(ovf2), 1);
`endif

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) begin
                thr_hi = 16'($urandom_range(20, 60));
                if ($urandom_range(0, 9) == 0)
                    thr_lo = thr_hi + 16'($urandom_range(1, 5));
                else
                    thr_lo = 16'($urandom_range(0, int'(thr_hi)));
            end
            clear = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 3) != 0, 16'($urandom_range(0, 80)));
        end
        clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
